memory_responder: RTL and testbench

Memory-side counterpart of the core data path's memory port. It accepts the data path's read address and its masked write (address, data, bit-mask) every cycle. It serves them from an internal word RAM and, optionally, from a memory-mapped machine timer, returning registered read data one cycle later. It sits between the data path and nothing else: it is the whole memory system of a single-core build.

---
 rtl/memory_responder.sv | 157 +++++++++++++++
 tb/tb_memory_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word RAM plus optional machine timer serving the data path memory port (timer: MEMORY_RESPONDER_TIMER_EN)
module memory_responder #(
    parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
    parameter int          RAM_ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
    parameter int          TIMER_DIVIDE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_memory_address,
    output logic [31:0] read_memory_data,
    input  logic [31:0] write_memory_address,
    input  logic [31:0] write_memory_data,
    input  logic [31:0] write_memory_mask,
    output logic        timer_interrupt
);

    localparam int          DEPTH  = 1 << RAM_ADDR_WIDTH;
    localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
    localparam logic [32:0] RAM_HI = RAM_LO + (33'd4 << RAM_ADDR_WIDTH);

    // Bit-granular merge shared by RAM and timer registers.
    function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [31:0] mask);
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    logic [31:0]               r_ram [DEPTH];
    logic [31:0]               r_read_data;

    logic                      w_rd_ram_hit;
    logic                      w_wr_ram_hit;
    logic                      w_wr_active;
    logic                      w_wr_ram;
    logic [RAM_ADDR_WIDTH-1:0] w_rd_index;
    logic [RAM_ADDR_WIDTH-1:0] w_wr_index;
    logic [31:0]               w_ram_rdata;
    logic                      w_rd_mmio_hit;
    logic [31:0]               w_mmio_rdata;
    logic [31:0]               w_rd_data;
    logic                      w_unused_addr_bits;

    // Range decode is done on the full address so any aligned base works.
    assign w_rd_ram_hit = ({1'b0, read_memory_address} >= RAM_LO) &&
                          ({1'b0, read_memory_address} <  RAM_HI);
    assign w_wr_ram_hit = ({1'b0, write_memory_address} >= RAM_LO) &&
                          ({1'b0, write_memory_address} <  RAM_HI);
    assign w_rd_index   = read_memory_address[RAM_ADDR_WIDTH+1:2];
    assign w_wr_index   = write_memory_address[RAM_ADDR_WIDTH+1:2];
    assign w_wr_active  = |write_memory_mask;
    assign w_wr_ram     = w_wr_ram_hit && w_wr_active;
    assign w_ram_rdata  = r_ram[w_rd_index];

    // Byte offsets within a word carry no meaning for a word-wide port.
    assign w_unused_addr_bits = &{1'b0, read_memory_address[1:0], write_memory_address[1:0]};

    // RAM write port; contents survive reset but no write lands while reset is held.
    always_ff @(posedge clk) begin
        if (reset && w_wr_ram) begin
            r_ram[w_wr_index] <= f_merge(r_ram[w_wr_index], write_memory_data, write_memory_mask);
        end
    end

`ifdef MEMORY_RESPONDER_TIMER_EN
    localparam int PW = (TIMER_DIVIDE > 1) ? $clog2(TIMER_DIVIDE) : 1;

    logic [PW-1:0] r_prescale;
    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;

    logic          w_tick;
    logic          w_wr_mmio;
    logic [1:0]    w_wr_sel;
    logic [PW-1:0] w_prescale_next;
    logic [63:0]   w_mtime_next;
    logic [63:0]   w_mtimecmp_next;

    assign w_rd_mmio_hit = (read_memory_address[31:4] == MMIO_BASE[31:4]);
    // RAM wins if a misconfigured map ever overlaps the timer window.
    assign w_wr_mmio     = (write_memory_address[31:4] == MMIO_BASE[31:4]) &&
                           w_wr_active && !w_wr_ram_hit;
    assign w_wr_sel      = write_memory_address[3:2];
    assign w_tick        = (r_prescale == PW'(TIMER_DIVIDE - 1));

    // Next timer state: a software write to an mtime half overrides that cycle's tick.
    always_comb begin
        w_prescale_next = w_tick ? '0 : r_prescale + PW'(1);
        w_mtime_next    = w_tick ? r_mtime + 64'd1 : r_mtime;
        w_mtimecmp_next = r_mtimecmp;
        if (w_wr_mmio) begin
            case (w_wr_sel)
                2'd0: w_mtime_next = {r_mtime[63:32],
                                      f_merge(r_mtime[31:0], write_memory_data, write_memory_mask)};
                2'd1: w_mtime_next = {f_merge(r_mtime[63:32], write_memory_data, write_memory_mask),
                                      r_mtime[31:0]};
                2'd2: w_mtimecmp_next = {r_mtimecmp[63:32],
                                         f_merge(r_mtimecmp[31:0], write_memory_data, write_memory_mask)};
                default: w_mtimecmp_next = {f_merge(r_mtimecmp[63:32], write_memory_data, write_memory_mask),
                                            r_mtimecmp[31:0]};
            endcase
        end
    end

    // Timer registers; compare value resets to all-ones so the interrupt starts low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prescale <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
        end else begin
            r_prescale <= w_prescale_next;
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
        end
    end

    // Register block read mux.
    always_comb begin
        w_mmio_rdata = 32'h0;
        case (read_memory_address[3:2])
            2'd0:    w_mmio_rdata = r_mtime[31:0];
            2'd1:    w_mmio_rdata = r_mtime[63:32];
            2'd2:    w_mmio_rdata = r_mtimecmp[31:0];
            default: w_mmio_rdata = r_mtimecmp[63:32];
        endcase
    end

    assign timer_interrupt = (r_mtime >= r_mtimecmp);
`else
    assign w_rd_mmio_hit   = 1'b0;
    assign w_mmio_rdata    = 32'h0;
    assign timer_interrupt = 1'b0;
`endif

    // Read source select; unmapped space reads as zero.
    always_comb begin
        w_rd_data = 32'h0;
        if (w_rd_ram_hit) begin
            w_rd_data = w_ram_rdata;
        end else if (w_rd_mmio_hit) begin
            w_rd_data = w_mmio_rdata;
        end
    end

    // Registered read data, one cycle after the address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_data <= 32'h0;
        end else begin
            r_read_data <= w_rd_data;
        end
    end

    assign read_memory_data = r_read_data;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed and random checks of memory_responder against a behavioural model
module tb_memory_responder;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam int          AW        = 12;
    localparam int          DEPTH     = 1 << AW;
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
    localparam int          DIV       = 1;
    localparam logic [31:0] FULL      = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [31:0] read_memory_address;
    logic [31:0] read_memory_data;
    logic [31:0] write_memory_address;
    logic [31:0] write_memory_data;
    logic [31:0] write_memory_mask;
    logic        timer_interrupt;

    memory_responder #(
        .RAM_BASE       (RAM_BASE),
        .RAM_ADDR_WIDTH (AW),
        .MMIO_BASE      (MMIO_BASE),
        .TIMER_DIVIDE   (DIV)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .read_memory_address  (read_memory_address),
        .read_memory_data     (read_memory_data),
        .write_memory_address (write_memory_address),
        .write_memory_data    (write_memory_data),
        .write_memory_mask    (write_memory_mask),
        .timer_interrupt      (timer_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_ram [int];
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    int          m_pre;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ram_hit(input logic [31:0] a);
        return ({2'b0, a} >= {2'b0, RAM_BASE}) && ({2'b0, a} < ({2'b0, RAM_BASE} + 34'(4 * DEPTH)));
    endfunction

    function automatic bit m_mmio_hit(input logic [31:0] a);
        return a[31:4] == MMIO_BASE[31:4];
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - RAM_BASE) >> 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (m_ram_hit(a)) begin
            if (ref_ram.exists(m_idx(a))) return ref_ram[m_idx(a)];
            known = 1'b0;
            return 32'h0;
        end
`ifdef MEMORY_RESPONDER_TIMER_EN
        if (m_mmio_hit(a)) begin
            case (a[3:2])
                2'd0:    return m_mtime[31:0];
                2'd1:    return m_mtime[63:32];
                2'd2:    return m_cmp[31:0];
                default: return m_cmp[63:32];
            endcase
        end
`endif
        return 32'h0;
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [31:0] m);
        return (o & ~m) | (d & m);
    endfunction

    // One clock edge of the memory system as seen from outside.
    task automatic m_edge(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] wm);
        logic [63:0] nt;
        nt = m_mtime;
        if (m_pre == DIV - 1) begin
            nt = m_mtime + 64'd1;
            m_pre = 0;
        end else begin
            m_pre = m_pre + 1;
        end
        if (wm != 32'h0) begin
            if (m_ram_hit(wa)) begin
                if (ref_ram.exists(m_idx(wa))) ref_ram[m_idx(wa)] = mrg(ref_ram[m_idx(wa)], wd, wm);
                else if (wm == FULL) ref_ram[m_idx(wa)] = wd;
            end
`ifdef MEMORY_RESPONDER_TIMER_EN
            else if (m_mmio_hit(wa)) begin
                case (wa[3:2])
                    2'd0:    nt = {m_mtime[63:32], mrg(m_mtime[31:0], wd, wm)};
                    2'd1:    nt = {mrg(m_mtime[63:32], wd, wm), m_mtime[31:0]};
                    2'd2:    m_cmp[31:0]  = mrg(m_cmp[31:0], wd, wm);
                    default: m_cmp[63:32] = mrg(m_cmp[63:32], wd, wm);
                endcase
            end
`endif
        end
        m_mtime = nt;
    endtask

    function automatic logic m_irq();
`ifdef MEMORY_RESPONDER_TIMER_EN
        return m_mtime >= m_cmp;
`else
        return 1'b0;
`endif
    endfunction

    task automatic cyc(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] wm, input string tag);
        logic [31:0] exp;
        bit          known;
        read_memory_address  = ra;
        write_memory_address = wa;
        write_memory_data    = wd;
        write_memory_mask    = wm;
        exp = m_read(ra, known);
        m_edge(wa, wd, wm);
        @(posedge clk);
        #1;
        if (known) chk({tag, "_rdata"}, {32'h0, read_memory_data}, {32'h0, exp});
        chk({tag, "_irq"}, {63'h0, timer_interrupt}, {63'h0, m_irq()});
    endtask

    // Reset mid-cycle with a RAM write pending; the write must not land.
    task automatic do_reset();
        write_memory_address = RAM_BASE + 32'h14;
        write_memory_data    = 32'hA5A5_5A5A;
        write_memory_mask    = FULL;
        reset = 1'b0;
        #1;
        chk("rst_async_rdata", {32'h0, read_memory_data}, 64'h0);
        chk("rst_async_irq", {63'h0, timer_interrupt}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_rdata", {32'h0, read_memory_data}, 64'h0);
        write_memory_mask = 32'h0;
        reset   = 1'b1;
        m_mtime = 64'h0;
        m_cmp   = '1;
        m_pre   = 0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = RAM_BASE + 32'(4 * $urandom_range(0, 15));
            6:       a = RAM_BASE + 32'(4 * (DEPTH - 1));
            7:       a = RAM_BASE + 32'(4 * DEPTH);
            8:       a = 32'h4000_0000 + 32'(4 * $urandom_range(0, 255));
            default: a = MMIO_BASE + 32'(4 * $urandom_range(0, 3));
        endcase
        return a | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] pick_mask();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return FULL;
            2:       return 32'hFF << (8 * $urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset                = 1'b0;
        read_memory_address  = 32'h0;
        write_memory_address = 32'h0;
        write_memory_data    = 32'h0;
        write_memory_mask    = 32'h0;
        m_mtime = 64'h0;
        m_cmp   = '1;
        m_pre   = 0;
        #12;
        chk("reset_rdata", {32'h0, read_memory_data}, 64'h0);
        chk("reset_irq", {63'h0, timer_interrupt}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 16; i++) cyc(32'h0, RAM_BASE + 32'(4 * i), $urandom, FULL, "init");
        cyc(32'h0, RAM_BASE + 32'(4 * (DEPTH - 1)), 32'h1357_9BDF, FULL, "init_top");

        cyc(32'h0, RAM_BASE + 32'h10, 32'hDEAD_BEEF, FULL, "wr_full");
        cyc(RAM_BASE + 32'h10, 32'h0, 32'h0, 32'h0, "rd_full");
        chk("deadbeef", {32'h0, read_memory_data}, {32'h0, 32'hDEAD_BEEF});
        cyc(32'h0, RAM_BASE + 32'h10, 32'h0000_5500, 32'h0000_FF00, "wr_part");
        cyc(RAM_BASE + 32'h10, 32'h0, 32'h0, 32'h0, "rd_part");
        chk("partial", {32'h0, read_memory_data}, {32'h0, 32'hDEAD_55EF});

        cyc(32'h0, RAM_BASE + 32'h20, 32'h1, FULL, "rf_old");
        cyc(RAM_BASE + 32'h20, RAM_BASE + 32'h20, 32'h2, FULL, "rf_same");
        chk("read_first_old", {32'h0, read_memory_data}, 64'h1);
        cyc(RAM_BASE + 32'h20, 32'h0, 32'h0, 32'h0, "rf_new");
        chk("read_first_new", {32'h0, read_memory_data}, 64'h2);

        cyc(32'h0, 32'h4000_0000, FULL, FULL, "unm_wr");
        cyc(32'h4000_0000, 32'h0, 32'h0, 32'h0, "unm_rd");
        chk("unmapped", {32'h0, read_memory_data}, 64'h0);
        cyc(32'h0, RAM_BASE + 32'(4 * DEPTH), FULL, FULL, "past_wr");
        cyc(RAM_BASE + 32'(4 * DEPTH), 32'h0, 32'h0, 32'h0, "past_rd");
        chk("past_top", {32'h0, read_memory_data}, 64'h0);
        cyc(RAM_BASE + 32'(4 * (DEPTH - 1)), 32'h0, 32'h0, 32'h0, "top_rd");
        chk("ram_top", {32'h0, read_memory_data}, {32'h0, 32'h1357_9BDF});

`ifdef MEMORY_RESPONDER_TIMER_EN
        cyc(32'h0, MMIO_BASE + 32'h4, 32'h0, FULL, "mt_hi0");
        cyc(32'h0, MMIO_BASE + 32'h0, 32'h0, FULL, "mt_lo0");
        cyc(32'h0, MMIO_BASE + 32'hC, 32'h0, FULL, "cmp_hi");
        cyc(32'h0, MMIO_BASE + 32'h8, 32'd20, FULL, "cmp_lo");
        for (int i = 0; i < 22; i++) cyc(MMIO_BASE, 32'h0, 32'h0, 32'h0, "count");
        chk("irq_set", {63'h0, timer_interrupt}, 64'h1);
        cyc(32'h0, MMIO_BASE + 32'h0, 32'h0, FULL, "mt_clear");
        chk("irq_drop", {63'h0, timer_interrupt}, 64'h0);
        cyc(32'h0, MMIO_BASE + 32'h0, FULL, FULL, "pre_lo");
        cyc(32'h0, MMIO_BASE + 32'h4, 32'h0, FULL, "pre_hi");
        cyc(32'h0, 32'h0, 32'h0, 32'h0, "carry");
        cyc(MMIO_BASE + 32'h4, 32'h0, 32'h0, 32'h0, "rd_hi");
        chk("carry_hi", {32'h0, read_memory_data}, 64'h1);
        cyc(MMIO_BASE + 32'h0, MMIO_BASE + 32'h4, FULL, FULL, "wrap_hi");
        cyc(MMIO_BASE + 32'h4, MMIO_BASE + 32'h0, FULL, FULL, "wrap_lo");
        cyc(MMIO_BASE + 32'h0, 32'h0, 32'h0, 32'h0, "wrap");
        cyc(MMIO_BASE + 32'h4, 32'h0, 32'h0, 32'h0, "wrap_rd");
        chk("wrap_hi_zero", {32'h0, read_memory_data}, 64'h0);
`else
        cyc(32'h0, MMIO_BASE + 32'h8, 32'h0, FULL, "mmio_wr");
        cyc(MMIO_BASE + 32'h8, 32'h0, 32'h0, 32'h0, "mmio_rd");
        chk("mmio_off", {32'h0, read_memory_data}, 64'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                cyc(RAM_BASE + 32'h14, 32'h0, 32'h0, 32'h0, "post_rst");
`ifdef MEMORY_RESPONDER_TIMER_EN
                cyc(MMIO_BASE + 32'h0, 32'h0, 32'h0, 32'h0, "post_rst_mt");
                chk("rst_mtime", {32'h0, read_memory_data}, 64'h1);
`endif
            end
            cyc(pick_addr(), pick_addr(), $urandom, pick_mask(), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
